// File: rtl/fft_fixed_pkg.sv
// ============================================================================
// Package : fft_fixed_pkg
// Brief   : Shared Q18.18 fixed-point word format and FSM encoding for the
//           FFT arithmetic blocks (divider and butterfly multiplier).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_fixed_pkg;

    localparam int WORD_SIZE = 37;
    localparam int HALF_SIZE = 18;
    localparam int ITER      = WORD_SIZE - 1 + HALF_SIZE;
    localparam int CNT_W     = 6;

    localparam logic [WORD_SIZE-1:0] FX_MAX_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/double_sign_div_if.sv
// ============================================================================
// Interface : double_sign_div_if
// Brief     : Operand/result valid-ready bus of the fixed-point divider.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface double_sign_div_if;
    import fft_fixed_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] A;
    logic [WORD_SIZE-1:0] B;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] C;
    logic                 div_zero;
    logic                 overflow;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, C, div_zero, overflow
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, C, div_zero, overflow
    );

endinterface

`default_nettype wire

// File: rtl/fx_sign_mag.sv
// ============================================================================
// Module : fx_sign_mag
// Brief  : Two's complement <-> sign/magnitude conversion by conditional
//          negation; the full word width keeps -2^(W-1) exact as a magnitude.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx_sign_mag
    import fft_fixed_pkg::*;
(
    input  logic                 neg,
    input  logic [WORD_SIZE-1:0] value_in,
    output logic [WORD_SIZE-1:0] value_out
);

    assign value_out = neg ? -value_in : value_in;

endmodule

`default_nettype wire

// File: rtl/double_sign_div.sv
// ============================================================================
// Module : double_sign_div
// Brief  : Iterative restoring signed Q18.18 divider, one quotient bit per
//          clock, with divide-by-zero and overflow saturation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module double_sign_div
    import fft_fixed_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    double_sign_div_if.slave bus
);

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_sign_q;
    logic [WORD_SIZE-1:0] r_mag_b;
    logic [ITER:0]        r_num;
    logic [WORD_SIZE-1:0] r_rem;
    logic [ITER-1:0]      r_quot;
    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_SIZE-1:0] r_c;
    logic                 r_div_zero;
    logic                 r_overflow;

    logic [WORD_SIZE-1:0] w_mag_a;
    logic [WORD_SIZE-1:0] w_mag_b;
    logic                 w_accept;
    logic                 w_b_zero;
    logic                 w_last;
    logic [WORD_SIZE:0]   w_rem_shift;
    logic                 w_ge;
    logic [WORD_SIZE-1:0] w_rem_diff;
    logic [ITER:0]        w_quot_fin;
    logic                 w_ovf;
    logic                 w_res_neg;
    logic [WORD_SIZE-1:0] w_res_mag;
    logic [WORD_SIZE-1:0] w_res_c;

    fx_sign_mag u_mag_a (
        .neg       (bus.A[WORD_SIZE-1]),
        .value_in  (bus.A),
        .value_out (w_mag_a)
    );

    fx_sign_mag u_mag_b (
        .neg       (bus.B[WORD_SIZE-1]),
        .value_in  (bus.B),
        .value_out (w_mag_b)
    );

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_b_zero = (bus.B == '0);
    assign w_last   = (r_cnt == '0);

    // Restoring step; remainder stays below magB, so the low WORD_SIZE bits
    // of the difference are exact.
    assign w_rem_shift = {r_rem, r_num[ITER]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_mag_b});
    assign w_rem_diff  = w_rem_shift[WORD_SIZE-1:0] - r_mag_b;
    assign w_quot_fin  = {r_quot, w_ge};
    assign w_ovf       = |w_quot_fin[ITER:WORD_SIZE-1];

    // In IDLE the result path serves the divide-by-zero case directly.
    always_comb begin
        w_res_neg = r_sign_q;
        w_res_mag = w_ovf ? FX_MAX_POS : {1'b0, w_quot_fin[WORD_SIZE-2:0]};
        if (r_state == IDLE) begin
            w_res_neg = bus.A[WORD_SIZE-1];
            w_res_mag = FX_MAX_POS;
        end
    end

    fx_sign_mag u_result (
        .neg       (w_res_neg),
        .value_in  (w_res_mag),
        .value_out (w_res_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = w_b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.C         = r_c;
        bus.div_zero  = r_div_zero;
        bus.overflow  = r_overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign_q   <= 1'b0;
            r_mag_b    <= '0;
            r_num      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_c        <= '0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_sign_q   <= bus.A[WORD_SIZE-1] ^ bus.B[WORD_SIZE-1];
            r_mag_b    <= w_mag_b;
            r_num      <= {w_mag_a, {HALF_SIZE{1'b0}}};
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= CNT_W'(ITER);
            r_div_zero <= w_b_zero;
            r_overflow <= 1'b0;
            if (w_b_zero) begin
                r_c <= w_res_c;
            end
        end else if (r_state == CALC) begin
            r_rem  <= w_ge ? w_rem_diff : w_rem_shift[WORD_SIZE-1:0];
            r_num  <= {r_num[ITER-1:0], 1'b0};
            r_quot <= w_quot_fin[ITER-1:0];
            r_cnt  <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_c        <= w_res_c;
                r_overflow <= w_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_double_sign_div.sv
// ============================================================================
// Module : tb_double_sign_div
// Brief  : Directed and randomized checks of double_sign_div against an
//          arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_double_sign_div;
    import fft_fixed_pkg::*;

    logic clk = 1'b0;
    logic rst;

    double_sign_div_if bus();

    double_sign_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam longint MAX_LI = (longint'(1) <<< (WORD_SIZE-1)) - 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_SIZE-1:0] neg37(input logic [WORD_SIZE-1:0] x);
        return -x;
    endfunction

    // Quotient of magnitudes scaled by 2^HALF_SIZE, truncated, then signed.
    function automatic void model(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b,
                                  output logic [WORD_SIZE-1:0] c, output logic dz, output logic ov);
        longint sa, sb, ma, mb, q, mag, cv;
        bit     neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        dz = (sb == 0);
        ov = 1'b0;
        if (dz) begin
            mag = MAX_LI;
            neg = (sa < 0);
        end else begin
            q   = (ma <<< HALF_SIZE) / mb;
            ov  = (q > MAX_LI);
            mag = ov ? MAX_LI : q;
            neg = ((sa < 0) != (sb < 0));
        end
        cv = neg ? -mag : mag;
        c  = cv[WORD_SIZE-1:0];
    endfunction

    function automatic logic [WORD_SIZE-1:0] rand_operand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return {1'b1, {(WORD_SIZE-1){1'b0}}};
            2:       return r[WORD_SIZE-1:0];
            3:       return {16'b0, r[20:0]};
            4:       return neg37({16'b0, r[20:0]});
            default: return {{8{r[36]}}, r[28:0]};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b,
                          input logic [WORD_SIZE-1:0] c_exp, input logic dz_exp, input logic ov_exp,
                          input int hold);
        int lat;
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            check({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = rand_operand();
        bus.B        = rand_operand();
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), (b == '0) ? 64'd0 : 64'(ITER + 1));
        check({tag, "_C"}, 64'(bus.C), 64'(c_exp));
        check({tag, "_flags"}, {62'b0, bus.div_zero, bus.overflow}, {62'b0, dz_exp, ov_exp});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.A        = rand_operand();
            bus.B        = rand_operand();
            @(posedge clk);
            #1;
            check({tag, "_hold_C"}, 64'(bus.C), 64'(c_exp));
            check({tag, "_hold_hs"}, {62'b0, bus.in_ready, bus.out_valid}, 64'b01);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_retire"}, {62'b0, bus.out_valid, bus.in_ready}, 64'b01);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [WORD_SIZE-1:0] a, b, c;
        logic                 dz, ov;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_C", 64'(bus.C), 64'd0);
        check("reset_flags", {62'b0, bus.div_zero, bus.overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("t1_half", 37'h0_0004_0000, 37'h0_0008_0000, 37'h0_0002_0000, 1'b0, 1'b0, 0);
        run_op("t2_neg", neg37(37'h0_000C_0000), 37'h0_0006_0000, neg37(37'h0_0008_0000), 1'b0, 1'b0, 0);
        run_op("t3_dz_neg", neg37(37'h0_0004_0000), '0, neg37(FX_MAX_POS), 1'b1, 1'b0, 0);
        run_op("t3_dz_zero", '0, '0, FX_MAX_POS, 1'b1, 1'b0, 0);

        // Reset in the middle of a calculation after a nonzero result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 37'h0_0014_0000;
        bus.B        = 37'h0_000C_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_busy", {62'b0, bus.in_ready, bus.out_valid}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_hs", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
        check("t6_rst_C", 64'(bus.C), 64'd0);
        check("t6_rst_flags", {62'b0, bus.div_zero, bus.overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t6_after", 37'h0_001C_0000, 37'h0_0008_0000, 37'h0_000E_0000, 1'b0, 1'b0, 0);

        run_op("t4_ovf", 37'h8_0000_0000, 37'h0_0000_0001, FX_MAX_POS, 1'b0, 1'b1, 0);
        run_op("t4_zero", 37'h0_0000_0001, 37'h10_0000_0000, '0, 1'b0, 1'b0, 0);
        run_op("t5_hold", 37'h0_0010_0000, neg37(37'h0_0008_0000), neg37(37'h0_0008_0000), 1'b0, 1'b0, 10);
        run_op("min_by_one", 37'h10_0000_0000, 37'h0_0004_0000, neg37(FX_MAX_POS), 1'b0, 1'b1, 0);
        run_op("trunc", 37'h0_0004_0000, 37'h0_000C_0000, 37'h0_0001_5555, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            a = rand_operand();
            b = rand_operand();
            model(a, b, c, dz, ov);
            run_op("rnd", a, b, c, dz, ov, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
